// File: rtl/libv_pkg.sv
// Shared command encoding and small helpers for the deque arbiter.
package libv_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH_FRONT = 2'd0,
        CMD_POP_FRONT  = 2'd1,
        CMD_PUSH_BACK  = 2'd2,
        CMD_POP_BACK   = 2'd3
    } cmd_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_push(input cmd_t c);
        return (c == CMD_PUSH_FRONT) || (c == CMD_PUSH_BACK);
    endfunction

    function automatic logic is_pop(input cmd_t c);
        return (c == CMD_POP_FRONT) || (c == CMD_POP_BACK);
    endfunction

endpackage

// File: rtl/libv_deque_arb_tagq.sv
// In-order FIFO of requester indices for pops issued to the deque and not yet answered.
module libv_deque_arb_tagq
    import libv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [TW-1:0] push_tag,
    input  logic          pop,
    output logic [TW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int PW = max(1, $clog2(DEPTH));
    localparam int CW = $clog2(DEPTH + 1);

    logic [TW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign head  = mem_q[rd_q];

    // Pop is taken first, so a full queue accepts a push in the same cycle.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        wr_d      = do_push_s ? ptr_inc(wr_q) : wr_q;
        rd_d      = do_pop_s ? ptr_inc(rd_q) : rd_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= push_tag;
        end else begin
            mem_q[wr_q] <= mem_q[wr_q];
        end
    end

endmodule

// File: rtl/libv_deque_arb.sv
// Round-robin arbiter sharing one deque among N requesters, with occupancy
// gating and in-order routing of pop responses back to their requester.
module libv_deque_arb
    import libv_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 32,
    parameter int DEPTH       = 16,
    parameter int OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 req_vld,
    input  cmd_t [N-1:0]                 req_cmd,
    input  logic [N-1:0][W-1:0]          req_dat,
    output logic [N-1:0]                 req_accept,
    output logic                         deq_cmd_vld,
    output cmd_t                         deq_cmd,
    output logic [W-1:0]                 deq_cmd_dat,
    input  logic                         deq_cmd_accept,
    input  logic                         deq_rsp_vld,
    input  logic [W-1:0]                 deq_rsp_dat,
    output logic [N-1:0]                 rsp_vld,
    output logic [W-1:0]                 rsp_dat,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int TW = max(1, $clog2(N));
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    logic          deq_cmd_vld_q, deq_cmd_vld_d;
    cmd_t          deq_cmd_q, deq_cmd_d;
    logic [W-1:0]  deq_cmd_dat_q, deq_cmd_dat_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [TW-1:0] rr_q, rr_d;
    logic          err_q, err_d;

    logic [N-1:0]  elig_s;
    logic          found_s;
    logic [TW-1:0] gnt_idx_s;
    logic          gnt_s;
    logic          slot_free_s;
    logic          tag_push_s;
    logic          tag_pop_s;
    logic          tag_full_s;
    logic          tag_empty_s;
    logic [TW-1:0] tag_head_s;
    int            idx;

    assign slot_free_s = !deq_cmd_vld_q || deq_cmd_accept;
    assign tag_pop_s   = rst_n && deq_rsp_vld && !tag_empty_s;

    // Eligibility and first-eligible search starting at the RR pointer.
    always_comb begin
        elig_s    = '0;
        found_s   = 1'b0;
        gnt_idx_s = '0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            if (!req_vld[i]) begin
                elig_s[i] = 1'b0;
            end else if (is_push(req_cmd[i])) begin
                elig_s[i] = (occ_q < OW'(DEPTH));
            end else begin
                // A response popping a tag this cycle frees room for a new pop.
                elig_s[i] = (occ_q != '0) && (!tag_full_s || tag_pop_s);
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_q) + k) % N;
            if (!found_s && elig_s[idx]) begin
                found_s   = 1'b1;
                gnt_idx_s = TW'(idx);
            end else begin
                found_s   = found_s;
            end
        end
    end

    assign gnt_s      = rst_n && slot_free_s && found_s;
    assign tag_push_s = gnt_s && is_pop(req_cmd[gnt_idx_s]);
    assign req_accept = gnt_s ? (ONE_HOT0 << gnt_idx_s) : '0;
    assign rsp_vld    = tag_pop_s ? (ONE_HOT0 << tag_head_s) : '0;
    assign rsp_dat    = deq_rsp_dat;

    // Next state for the output slot, pointer, occupancy and error flag.
    always_comb begin
        deq_cmd_vld_d = deq_cmd_vld_q;
        deq_cmd_d     = deq_cmd_q;
        deq_cmd_dat_d = deq_cmd_dat_q;
        rr_d          = rr_q;
        occ_d         = occ_q;
        err_d         = err_q;
        if (gnt_s) begin
            deq_cmd_vld_d = 1'b1;
            deq_cmd_d     = req_cmd[gnt_idx_s];
            deq_cmd_dat_d = req_dat[gnt_idx_s];
            rr_d          = (gnt_idx_s == TW'(N - 1)) ? '0 : gnt_idx_s + TW'(1);
            occ_d         = is_push(req_cmd[gnt_idx_s]) ? occ_q + OW'(1) : occ_q - OW'(1);
        end else if (deq_cmd_accept) begin
            deq_cmd_vld_d = 1'b0;
        end else begin
            deq_cmd_vld_d = deq_cmd_vld_q;
        end
        if (deq_rsp_vld && tag_empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deq_cmd_vld_q <= 1'b0;
            deq_cmd_q     <= CMD_PUSH_FRONT;
            deq_cmd_dat_q <= '0;
            rr_q          <= '0;
            occ_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            deq_cmd_vld_q <= deq_cmd_vld_d;
            deq_cmd_q     <= deq_cmd_d;
            deq_cmd_dat_q <= deq_cmd_dat_d;
            rr_q          <= rr_d;
            occ_q         <= occ_d;
            err_q         <= err_d;
        end
    end

    libv_deque_arb_tagq #(
        .DEPTH (OUTSTANDING),
        .TW    (TW)
    ) u_tagq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tag_push_s),
        .push_tag (gnt_idx_s),
        .pop      (tag_pop_s),
        .head     (tag_head_s),
        .full     (tag_full_s),
        .empty    (tag_empty_s)
    );

    assign deq_cmd_vld = deq_cmd_vld_q;
    assign deq_cmd     = deq_cmd_q;
    assign deq_cmd_dat = deq_cmd_dat_q;
    assign occ         = occ_q;
    assign full        = (occ_q == OW'(DEPTH));
    assign empty       = (occ_q == '0);
    assign err         = err_q;

endmodule
